// File: rtl/l2_req_scheduler.sv
// l2_req_scheduler
// Sequencer in front of the L2 lookup/MESI engine. L1 and bus-snoop requests
// each land in a single-entry holding register (valid/ready). An arbiter
// grants one held request at a time, with snoop priority bounded by an L1
// anti-starvation streak limit. It then offers the request to the engine as a
// cache opcode plus address, and waits for the engine's completion pulse.
// A watchdog aborts the wait if the pulse never arrives.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   l1_valid/l1_ready/l1_op/l1_addr   L1 request port (op 3 is illegal)
//   sn_valid/sn_ready/sn_op/sn_addr   snoop request port
//   eng_valid/eng_ready/eng_op/eng_addr  transaction offered to the engine
//   eng_done                   one-cycle completion pulse from the engine
//   busy                       FSM is in ISSUE or WAIT
//   timeout_err, illegal_op    sticky error flags
//   l1_grant_cnt, sn_grant_cnt saturating grant counters
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | arbitrate between the held requests
// ISSUE  | eng_valid high, waiting for eng_ready
// WAIT   | transaction accepted, waiting for eng_done or the watchdog
module l2_req_scheduler #(
   parameter int MAX_SNOOP_STREAK = 4,
   parameter int DONE_TIMEOUT     = 64,
   parameter int CNT_W            = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             l1_valid,
   output logic             l1_ready,
   input  logic [1:0]       l1_op,
   input  logic [31:0]      l1_addr,
   input  logic             sn_valid,
   output logic             sn_ready,
   input  logic [1:0]       sn_op,
   input  logic [31:0]      sn_addr,
   output logic             eng_valid,
   input  logic             eng_ready,
   output logic [2:0]       eng_op,
   output logic [31:0]      eng_addr,
   input  logic             eng_done,
   output logic             busy,
   output logic             timeout_err,
   output logic             illegal_op,
   output logic [CNT_W-1:0] l1_grant_cnt,
   output logic [CNT_W-1:0] sn_grant_cnt
);

   localparam int STRK_W = (MAX_SNOOP_STREAK < 1) ? 1 : $clog2(MAX_SNOOP_STREAK + 1);
   localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(MAX_SNOOP_STREAK);
   // Down-counter terminal count is zero, so loading TIMEOUT-1 gives exactly
   // DONE_TIMEOUT edges in WAIT before the abort.
   localparam logic [15:0]       WD_LOAD  = 16'(DONE_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t            state_q;
   logic              l1_held_q, sn_held_q;
   logic [1:0]        l1_op_q, sn_op_q;
   logic [31:0]       l1_addr_q, sn_addr_q;
   logic              eng_valid_q;
   logic [2:0]        eng_op_q;
   logic [31:0]       eng_addr_q;
   logic              timeout_q, illegal_q;
   logic [CNT_W-1:0]  l1_cnt_q, sn_cnt_q;
   logic [CNT_W-1:0]  l1_cnt_d, sn_cnt_d;
   logic [STRK_W-1:0] streak_q;
   logic [15:0]       wd_q;

   logic l1_acc, sn_acc, l1_legal;
   logic grant_sn, grant_l1;

   assign l1_ready = ~l1_held_q;
   assign sn_ready = ~sn_held_q;
   assign l1_acc   = l1_valid & ~l1_held_q;
   assign sn_acc   = sn_valid & ~sn_held_q;
   assign l1_legal = (l1_op != 2'd3);

   // Snoop wins unless an L1 request has already waited out the full streak.
   assign grant_sn = (state_q == ST_IDLE) & sn_held_q &
                     (~l1_held_q | (streak_q != STRK_MAX));
   assign grant_l1 = (state_q == ST_IDLE) & l1_held_q & ~grant_sn;

   assign l1_cnt_d = (&l1_cnt_q) ? l1_cnt_q : l1_cnt_q + CNT_W'(1);
   assign sn_cnt_d = (&sn_cnt_q) ? sn_cnt_q : sn_cnt_q + CNT_W'(1);

   // Holding registers. A grant and a new accept are exclusive because ready
   // is low while the register is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l1_held_q <= 1'b0;
         l1_op_q   <= 2'd0;
         l1_addr_q <= 32'd0;
         sn_held_q <= 1'b0;
         sn_op_q   <= 2'd0;
         sn_addr_q <= 32'd0;
         illegal_q <= 1'b0;
      end else begin
         if (grant_l1) begin
            l1_held_q <= 1'b0;
         end else if (l1_acc) begin
            if (l1_legal) begin
               l1_held_q <= 1'b1;
               l1_op_q   <= l1_op;
               l1_addr_q <= l1_addr;
            end else begin
               illegal_q <= 1'b1;
            end
         end
         if (grant_sn) begin
            sn_held_q <= 1'b0;
         end else if (sn_acc) begin
            sn_held_q <= 1'b1;
            sn_op_q   <= sn_op;
            sn_addr_q <= sn_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         eng_valid_q <= 1'b0;
         eng_op_q    <= 3'd0;
         eng_addr_q  <= 32'd0;
         timeout_q   <= 1'b0;
         l1_cnt_q    <= '0;
         sn_cnt_q    <= '0;
         streak_q    <= '0;
         wd_q        <= 16'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_sn) begin
                  eng_valid_q <= 1'b1;
                  eng_op_q    <= {1'b0, sn_op_q} + 3'd3;
                  eng_addr_q  <= sn_addr_q;
                  sn_cnt_q    <= sn_cnt_d;
                  // The streak only measures how long a held L1 has waited.
                  if (l1_held_q) streak_q <= streak_q + STRK_W'(1);
                  state_q     <= ST_ISSUE;
               end else if (grant_l1) begin
                  eng_valid_q <= 1'b1;
                  eng_op_q    <= {1'b0, l1_op_q};
                  eng_addr_q  <= l1_addr_q;
                  l1_cnt_q    <= l1_cnt_d;
                  streak_q    <= '0;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (eng_ready) begin
                  eng_valid_q <= 1'b0;
                  wd_q        <= WD_LOAD;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (eng_done) begin
                  state_q <= ST_IDLE;
               end else if (wd_q == 16'd0) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end else begin
                  wd_q <= wd_q - 16'd1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               eng_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign eng_valid    = eng_valid_q;
   assign eng_op       = eng_op_q;
   assign eng_addr     = eng_addr_q;
   assign busy         = (state_q != ST_IDLE);
   assign timeout_err  = timeout_q;
   assign illegal_op   = illegal_q;
   assign l1_grant_cnt = l1_cnt_q;
   assign sn_grant_cnt = sn_cnt_q;

endmodule

// File: tb/tb_l2_req_scheduler.sv
module tb_l2_req_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        l1_valid, l1_ready;
   logic [1:0]  l1_op;
   logic [31:0] l1_addr;
   logic        sn_valid, sn_ready;
   logic [1:0]  sn_op;
   logic [31:0] sn_addr;
   logic        eng_valid, eng_ready;
   logic [2:0]  eng_op;
   logic [31:0] eng_addr;
   logic        eng_done;
   logic        busy, timeout_err, illegal_op;
   logic [15:0] l1_grant_cnt, sn_grant_cnt;

   logic resp_done = 1'b0;
   logic man_done  = 1'b0;
   logic done_en   = 1'b1;
   assign eng_done = resp_done | man_done;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
   } txn_t;
   txn_t exp_q[$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   l2_req_scheduler #(.MAX_SNOOP_STREAK(4), .DONE_TIMEOUT(64), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_op(l1_op), .l1_addr(l1_addr),
      .sn_valid(sn_valid), .sn_ready(sn_ready), .sn_op(sn_op), .sn_addr(sn_addr),
      .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_op(eng_op), .eng_addr(eng_addr),
      .eng_done(eng_done), .busy(busy), .timeout_err(timeout_err), .illegal_op(illegal_op),
      .l1_grant_cnt(l1_grant_cnt), .sn_grant_cnt(sn_grant_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bound_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   // Scoreboard monitor: every engine handshake pops one expected transaction.
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (rst_n && eng_valid && eng_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_issue: got op=%0d addr=0x%h expected none", eng_op, eng_addr);
            end else begin
               t = exp_q.pop_front();
               check("eng_op", 64'(eng_op), 64'(t.op));
               check("eng_addr", 64'(eng_addr), 64'(t.addr));
            end
         end
      end
   end

   // Engine model: done pulse on the first WAIT cycle when enabled.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && eng_valid && eng_ready) begin
            @(posedge clk); #1;
            resp_done = done_en;
            @(posedge clk); #1;
            resp_done = 1'b0;
         end
      end
   end

   task automatic l1_send(input logic [1:0] op, input logic [31:0] addr);
      int n = 0;
      l1_op = op;
      l1_addr = addr;
      while (!l1_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!l1_ready) bound_fail("l1_send");
      l1_valid = 1'b1;
      @(posedge clk); #1;
      l1_valid = 1'b0;
   endtask

   task automatic sn_send(input logic [1:0] op, input logic [31:0] addr);
      int n = 0;
      sn_op = op;
      sn_addr = addr;
      while (!sn_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (!sn_ready) bound_fail("sn_send");
      sn_valid = 1'b1;
      @(posedge clk); #1;
      sn_valid = 1'b0;
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      while ((busy || !l1_ready || !sn_ready || exp_q.size() != 0) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 300) bound_fail(name);
   endtask

   initial begin
      int n;
      int viol;
      l1_valid = 1'b0; l1_op = 2'd0; l1_addr = 32'd0;
      sn_valid = 1'b0; sn_op = 2'd0; sn_addr = 32'd0;
      eng_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_l1_ready", 64'(l1_ready), 64'd1);
      check("rst_sn_ready", 64'(sn_ready), 64'd1);
      check("rst_eng_valid", 64'(eng_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_eng_op", 64'(eng_op), 64'd0);
      check("rst_eng_addr", 64'(eng_addr), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single L1 read
      exp_q.push_back('{3'd0, 32'h0001_2340});
      l1_send(2'd0, 32'h0001_2340);
      check("t1_l1_ready_held", 64'(l1_ready), 64'd0);
      @(posedge clk); #1;
      check("t1_eng_valid", 64'(eng_valid), 64'd1);
      check("t1_eng_op", 64'(eng_op), 64'd0);
      check("t1_eng_addr", 64'(eng_addr), 64'h0001_2340);
      check("t1_l1_ready_after_grant", 64'(l1_ready), 64'd1);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy) n++;
         else break;
      end
      check("t1_busy_cycles", 64'(n), 64'd2);
      wait_quiet("t1_quiet");
      check("t1_l1_cnt", 64'(l1_grant_cnt), 64'd1);

      // Simultaneous L1 write and snoop RWIM: snoop first
      exp_q.push_back('{3'd5, 32'hB000_0080});
      exp_q.push_back('{3'd1, 32'hA000_0040});
      fork
         l1_send(2'd1, 32'hA000_0040);
         sn_send(2'd2, 32'hB000_0080);
      join
      wait_quiet("t2_quiet");
      check("t2_sn_cnt", 64'(sn_grant_cnt), 64'd1);
      check("t2_l1_cnt", 64'(l1_grant_cnt), 64'd2);

      // Starvation: 4 snoops, then L1, then snoops resume
      for (int i = 0; i < 4; i++)
         exp_q.push_back('{3'(i % 4) + 3'd3, 32'h0000_2000 + 32'(i * 64)});
      exp_q.push_back('{3'd2, 32'h0000_0100});
      for (int i = 4; i < 7; i++)
         exp_q.push_back('{3'(i % 4) + 3'd3, 32'h0000_2000 + 32'(i * 64)});
      fork
         l1_send(2'd2, 32'h0000_0100);
         begin
            for (int i = 0; i < 7; i++) sn_send(2'(i % 4), 32'h0000_2000 + 32'(i * 64));
         end
      join
      wait_quiet("t3_quiet");
      check("t3_sn_cnt", 64'(sn_grant_cnt), 64'd8);
      check("t3_l1_cnt", 64'(l1_grant_cnt), 64'd3);

      // Watchdog: no done; accept at a, grant a+1, WAIT at a+2, abort at a+66
      done_en = 1'b0;
      exp_q.push_back('{3'd0, 32'hC000_0000});
      exp_q.push_back('{3'd4, 32'hD000_0000});
      l1_send(2'd0, 32'hC000_0000);
      fork
         sn_send(2'd1, 32'hD000_0000);
      join_none
      n = 0;
      while (!timeout_err && n < 200) begin @(posedge clk); #1; n++; end
      check("t4_timeout_latency", 64'(n), 64'd66);
      check("t4_timeout_err", 64'(timeout_err), 64'd1);
      check("t4_busy_after_abort", 64'(busy), 64'd0);
      done_en = 1'b1;
      wait_quiet("t4_quiet");
      check("t4_sn_cnt", 64'(sn_grant_cnt), 64'd9);
      check("t4_l1_cnt", 64'(l1_grant_cnt), 64'd4);

      // Illegal L1 opcode
      l1_send(2'd3, 32'h1234_5678);
      check("t5_illegal_op", 64'(illegal_op), 64'd1);
      check("t5_l1_ready", 64'(l1_ready), 64'd1);
      viol = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (eng_valid || busy || !l1_ready) viol++;
      end
      check("t5_no_issue", 64'(viol), 64'd0);
      check("t5_l1_cnt", 64'(l1_grant_cnt), 64'd4);

      // Reset in WAIT with both holding registers full
      done_en = 1'b0;
      exp_q.push_back('{3'd1, 32'hE000_0000});
      l1_send(2'd1, 32'hE000_0000);
      @(posedge clk); #1;
      fork
         l1_send(2'd2, 32'hE100_0000);
         sn_send(2'd3, 32'hF000_0000);
      join
      @(posedge clk); #1;
      check("t6_busy_wait", 64'(busy), 64'd1);
      check("t6_both_held", 64'({l1_ready, sn_ready}), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_ready", 64'({l1_ready, sn_ready}), 64'd3);
      check("t6_rst_eng", 64'({eng_valid, eng_op, busy}), 64'd0);
      check("t6_rst_eng_addr", 64'(eng_addr), 64'd0);
      check("t6_rst_flags", 64'({timeout_err, illegal_op}), 64'd0);
      check("t6_rst_cnts", 64'({l1_grant_cnt, sn_grant_cnt}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      man_done = 1'b1;
      @(posedge clk); #1;
      man_done = 1'b0;
      viol = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (eng_valid || busy || !l1_ready || !sn_ready) viol++;
      end
      check("t6_no_issue_after_reset", 64'(viol), 64'd0);
      done_en = 1'b1;

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l2_req_scheduler.md
Name: l2_req_scheduler

Overview:
- Sequencer in front of the L2 cache lookup/MESI engine.
- Accepts processor-side (L1) requests and bus-snoop requests on two independent valid/ready ports, each with a single-entry holding register.
- Arbitrates between them with snoop priority and an L1 anti-starvation limit.
- Issues exactly one transaction at a time to the engine as a cache opcode (0–6) plus address, then waits for a completion pulse, with a watchdog timeout.

Parameters:
- MAX_SNOOP_STREAK, 4, consecutive snoop grants allowed while an L1 request is held; the next grant goes to L1.
- DONE_TIMEOUT, 64, cycles allowed in WAIT before forced abort; 1..65535.
- CNT_W, 16, width of the saturating grant counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- l1_valid  in  1  L1 request present.
- l1_ready  out  1  L1 holding register empty.
- l1_op  in  2  0 = data read, 1 = data write, 2 = instruction read; 3 is illegal.
- l1_addr  in  32  L1 request address.
- sn_valid  in  1  snoop request present.
- sn_ready  out  1  snoop holding register empty.
- sn_op  in  2  0 = read, 1 = write, 2 = RWIM, 3 = invalidate.
- sn_addr  in  32  snooped address.
- eng_valid  out  1  transaction offered to the engine.
- eng_ready  in  1  engine accepts the transaction.
- eng_op  out  3  cache opcode: L1 = l1_op; snoop = sn_op + 3.
- eng_addr  out  32  transaction address.
- eng_done  in  1  one-cycle completion pulse from the engine.
- busy  out  1  high in ISSUE or WAIT.
- timeout_err  out  1  sticky; set on a watchdog abort.
- illegal_op  out  1  sticky; set when an L1 request with l1_op = 3 is accepted.
- l1_grant_cnt  out  CNT_W  saturating count of L1 grants.
- sn_grant_cnt  out  CNT_W  saturating count of snoop grants.

Behaviour:
- Reset (async, rst_n low):
  - Both holding registers empty, so l1_ready = sn_ready = 1.
  - FSM in IDLE; eng_valid = 0, eng_op = 0, eng_addr = 0, busy = 0.
  - timeout_err = 0, illegal_op = 0, both counters 0, streak = 0, watchdog = 0.
  - Reset mid-transaction discards held and in-flight requests; no done is expected afterwards.
- Holding registers:
  - ready = !held, taken from registered state; there is no same-cycle bypass.
  - A valid&ready handshake at edge t loads the register.
  - The register clears on the edge on which it is granted. Ready rises the following cycle; a new request can be accepted no earlier than the cycle after the grant.
- Illegal L1 opcode: l1_op = 3 sets illegal_op and is dropped. It is never held and never issued.
- IDLE state:
  - Arbitration uses held registers only.
  - Only one side held: grant that side.
  - Both held: grant snoop, unless streak == MAX_SNOOP_STREAK, in which case grant L1.
  - Streak update: +1 on a snoop grant while L1 is held; cleared on any L1 grant; unchanged on a snoop grant with no L1 held.
  - On a grant: load eng_op/eng_addr, set eng_valid, go to ISSUE, increment that side's counter (saturating at all-ones).
  - Latency: request accepted at edge t gives eng_valid high after edge t+1, if IDLE.
- ISSUE state:
  - eng_valid held high; eng_op and eng_addr stable.
  - eng_valid&eng_ready: drop eng_valid, clear watchdog, go to WAIT.
  - eng_done is ignored in ISSUE.
- WAIT state:
  - eng_done: go to IDLE; a new grant can occur on the next edge.
  - Watchdog counts each cycle in WAIT. Reaching DONE_TIMEOUT without done: set timeout_err, go to IDLE.
  - A late eng_done outside WAIT is ignored.
- Throughput: at most one transaction per 3 cycles (IDLE→ISSUE→WAIT→IDLE with immediate ready and done).
- busy = (state != IDLE).
- No address comparison or reordering; requests are issued in grant order.

Test Plan:
- Single L1 read: addr 0x0001_2340, op 0; eng_ready and eng_done each after 1 cycle → eng_op = 0, eng_addr = 0x0001_2340 one edge after acceptance; busy for 2 cycles; l1_grant_cnt = 1.
- Simultaneous L1 write 0xA000_0040 and snoop RWIM 0xB000_0080 → snoop issued first with eng_op = 5, then L1 with eng_op = 1; sn_grant_cnt = 1, l1_grant_cnt = 1.
- Starvation: L1 held while snoops arrive back-to-back, MAX_SNOOP_STREAK = 4 → exactly 4 snoop grants, then the L1 grant, then snoops resume.
- Watchdog: DONE_TIMEOUT = 64 with eng_done never asserted → timeout_err set 64 cycles after WAIT entry; FSM returns to IDLE and the next held request issues.
- Illegal opcode: l1_op = 3 → illegal_op = 1, eng_valid stays 0, l1_ready stays 1.
- Reset while in WAIT with both holding registers full → all outputs at reset values; a following eng_done pulse causes no issue.
